// File: rtl/axi_mem_arbiter.sv
// 2:1 AXI4 arbiter sharing one axi_mem slave port between M0 (L1D) and M1 (L1I/PTW).
// Define AXI_MEM_ARB_FIXED_PRIO_EN for fixed M0 > M1 priority; the default build uses round-robin.
`timescale 1ns/1ps

module axi_mem_arbiter #(
    parameter int ID_WIDTH       = 4,
    parameter int AXI_DATA_WIDTH = 512,
    parameter int MAX_W_OUTST    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,

    input  logic [1:0][ID_WIDTH-1:0]             i_m_arid,
    input  logic [1:0][31:0]                     i_m_araddr,
    input  logic [1:0][7:0]                      i_m_arlen,
    input  logic [1:0][2:0]                      i_m_arsize,
    input  logic [1:0][1:0]                      i_m_arburst,
    input  logic [1:0]                           i_m_arvalid,
    output logic [1:0]                           o_m_arready,

    input  logic [1:0][ID_WIDTH-1:0]             i_m_awid,
    input  logic [1:0][31:0]                     i_m_awaddr,
    input  logic [1:0][7:0]                      i_m_awlen,
    input  logic [1:0][2:0]                      i_m_awsize,
    input  logic [1:0][1:0]                      i_m_awburst,
    input  logic [1:0]                           i_m_awvalid,
    output logic [1:0]                           o_m_awready,

    input  logic [1:0][AXI_DATA_WIDTH-1:0]       i_m_wdata,
    input  logic [1:0][AXI_DATA_WIDTH/8-1:0]     i_m_wstrb,
    input  logic [1:0]                           i_m_wlast,
    input  logic [1:0]                           i_m_wvalid,
    output logic [1:0]                           o_m_wready,

    output logic [1:0][ID_WIDTH-1:0]             o_m_bid,
    output logic [1:0][1:0]                      o_m_bresp,
    output logic [1:0]                           o_m_bvalid,
    input  logic [1:0]                           i_m_bready,

    output logic [1:0][ID_WIDTH-1:0]             o_m_rid,
    output logic [1:0][AXI_DATA_WIDTH-1:0]       o_m_rdata,
    output logic [1:0][1:0]                      o_m_rresp,
    output logic [1:0]                           o_m_rlast,
    output logic [1:0]                           o_m_rvalid,
    input  logic [1:0]                           i_m_rready,

    output logic [ID_WIDTH:0]                    o_s_arid,
    output logic [31:0]                          o_s_araddr,
    output logic [7:0]                           o_s_arlen,
    output logic [2:0]                           o_s_arsize,
    output logic [1:0]                           o_s_arburst,
    output logic                                 o_s_arvalid,
    input  logic                                 i_s_arready,

    output logic [ID_WIDTH:0]                    o_s_awid,
    output logic [31:0]                          o_s_awaddr,
    output logic [7:0]                           o_s_awlen,
    output logic [2:0]                           o_s_awsize,
    output logic [1:0]                           o_s_awburst,
    output logic                                 o_s_awvalid,
    input  logic                                 i_s_awready,

    output logic [AXI_DATA_WIDTH-1:0]            o_s_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]          o_s_wstrb,
    output logic                                 o_s_wlast,
    output logic                                 o_s_wvalid,
    input  logic                                 i_s_wready,

    input  logic [ID_WIDTH:0]                    i_s_bid,
    input  logic [1:0]                           i_s_bresp,
    input  logic                                 i_s_bvalid,
    output logic                                 o_s_bready,

    input  logic [ID_WIDTH:0]                    i_s_rid,
    input  logic [AXI_DATA_WIDTH-1:0]            i_s_rdata,
    input  logic [1:0]                           i_s_rresp,
    input  logic                                 i_s_rlast,
    input  logic                                 i_s_rvalid,
    output logic                                 o_s_rready
);

    localparam int OW = $clog2(MAX_W_OUTST + 1);
    localparam logic [OW-1:0] OUTST_LIMIT = OW'(MAX_W_OUTST);

`ifdef AXI_MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    typedef enum logic {W_IDLE = 1'b0, W_BUSY = 1'b1} w_state_t;

    w_state_t       w_state, w_state_nxt;
    logic           rr_ar, rr_aw, w_owner;
    logic           ar_pend, ar_pend_sel, aw_pend, aw_pend_sel;
    logic           ar_sel, aw_sel, aw_en, w_busy;
    logic           ar_fire, aw_fire, w_last_fire, b_fire;
    logic [OW-1:0]  w_outst;
    logic           r_dst, b_dst;

    // A request left waiting on slave ready keeps its grant so valid/ready never drops mid-handshake.
    always_comb begin
        if (ar_pend)
            ar_sel = ar_pend_sel;
        else if (&i_m_arvalid)
            ar_sel = rr_ar;
        else
            ar_sel = i_m_arvalid[1];
    end

    always_comb begin
        o_s_arvalid          = rst_n & i_m_arvalid[ar_sel];
        o_s_arid             = {ar_sel, i_m_arid[ar_sel]};
        o_s_araddr           = i_m_araddr[ar_sel];
        o_s_arlen            = i_m_arlen[ar_sel];
        o_s_arsize           = i_m_arsize[ar_sel];
        o_s_arburst          = i_m_arburst[ar_sel];
        o_m_arready          = '0;
        o_m_arready[ar_sel]  = o_s_arvalid & i_s_arready;
    end

    assign ar_fire = o_s_arvalid & i_s_arready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ar       <= 1'b0;
            ar_pend     <= 1'b0;
            ar_pend_sel <= 1'b0;
        end else begin
            ar_pend     <= o_s_arvalid & ~i_s_arready;
            ar_pend_sel <= ar_sel;
            if (ar_fire)
                rr_ar <= FIXED_PRIO ? 1'b0 : ~ar_sel;
        end
    end

    // AW is only offered between bursts and while the outstanding-B budget has room.
    assign aw_en  = (w_state == W_IDLE) && (w_outst < OUTST_LIMIT);
    assign w_busy = (w_state == W_BUSY);

    always_comb begin
        if (aw_pend)
            aw_sel = aw_pend_sel;
        else if (&i_m_awvalid)
            aw_sel = rr_aw;
        else
            aw_sel = i_m_awvalid[1];
    end

    always_comb begin
        o_s_awvalid          = rst_n & aw_en & i_m_awvalid[aw_sel];
        o_s_awid             = {aw_sel, i_m_awid[aw_sel]};
        o_s_awaddr           = i_m_awaddr[aw_sel];
        o_s_awlen            = i_m_awlen[aw_sel];
        o_s_awsize           = i_m_awsize[aw_sel];
        o_s_awburst          = i_m_awburst[aw_sel];
        o_m_awready          = '0;
        o_m_awready[aw_sel]  = o_s_awvalid & i_s_awready;
    end

    assign aw_fire = o_s_awvalid & i_s_awready;

    always_comb begin
        o_s_wvalid          = rst_n & w_busy & i_m_wvalid[w_owner];
        o_s_wdata           = i_m_wdata[w_owner];
        o_s_wstrb           = i_m_wstrb[w_owner];
        o_s_wlast           = i_m_wlast[w_owner];
        o_m_wready          = '0;
        o_m_wready[w_owner] = rst_n & w_busy & i_s_wready;
    end

    assign w_last_fire = o_s_wvalid & i_s_wready & i_m_wlast[w_owner];

    always_ff @(posedge clk) begin
        if (!rst_n)
            w_state <= W_IDLE;
        else
            w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE: if (aw_fire)     w_state_nxt = W_BUSY;
            W_BUSY: if (w_last_fire) w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_aw       <= 1'b0;
            aw_pend     <= 1'b0;
            aw_pend_sel <= 1'b0;
            w_owner     <= 1'b0;
            w_outst     <= '0;
        end else begin
            aw_pend     <= o_s_awvalid & ~i_s_awready;
            aw_pend_sel <= aw_sel;
            if (aw_fire) begin
                w_owner <= aw_sel;
                rr_aw   <= FIXED_PRIO ? 1'b0 : ~aw_sel;
            end
            case ({aw_fire, b_fire})
                2'b10:   w_outst <= w_outst + OW'(1);
                2'b01:   w_outst <= w_outst - OW'(1);
                default: w_outst <= w_outst;
            endcase
        end
    end

    // Responses route purely on the ID MSB the arbiter prepended; no buffering.
    assign r_dst  = i_s_rid[ID_WIDTH];
    assign b_dst  = i_s_bid[ID_WIDTH];
    assign b_fire = i_s_bvalid & o_s_bready;

    always_comb begin
        o_m_rvalid        = '0;
        o_m_rvalid[r_dst] = rst_n & i_s_rvalid;
        o_s_rready        = rst_n & i_m_rready[r_dst];
        o_m_bvalid        = '0;
        o_m_bvalid[b_dst] = rst_n & i_s_bvalid;
        o_s_bready        = rst_n & i_m_bready[b_dst];
        for (int i = 0; i < 2; i++) begin
            o_m_rid[i]   = i_s_rid[ID_WIDTH-1:0];
            o_m_rdata[i] = i_s_rdata;
            o_m_rresp[i] = i_s_rresp;
            o_m_rlast[i] = i_s_rlast;
            o_m_bid[i]   = i_s_bid[ID_WIDTH-1:0];
            o_m_bresp[i] = i_s_bresp;
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Scoreboard bench for axi_mem_arbiter; the bench itself plays the axi_mem slave.
`timescale 1ns/1ps

module tb_axi_mem_arbiter;

    localparam int IDW = 4;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;
    localparam logic [IDW-1:0] M0_ID = 4'h3;
    localparam logic [IDW-1:0] M1_ID = 4'hA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][IDW-1:0] m_arid, m_awid;
    logic [1:0][31:0]    m_araddr, m_awaddr;
    logic [1:0][7:0]     m_arlen, m_awlen;
    logic [1:0][2:0]     m_arsize, m_awsize;
    logic [1:0][1:0]     m_arburst, m_awburst;
    logic [1:0]          m_arvalid, m_awvalid, o_m_arready, o_m_awready;
    logic [1:0][DW-1:0]  m_wdata;
    logic [1:0][SW-1:0]  m_wstrb;
    logic [1:0]          m_wlast, m_wvalid, o_m_wready;
    logic [1:0][IDW-1:0] o_m_bid, o_m_rid;
    logic [1:0][1:0]     o_m_bresp, o_m_rresp;
    logic [1:0]          o_m_bvalid, m_bready, o_m_rlast, o_m_rvalid, m_rready;
    logic [1:0][DW-1:0]  o_m_rdata;
    logic [IDW:0]        o_s_arid, o_s_awid, s_bid, s_rid;
    logic [31:0]         o_s_araddr, o_s_awaddr;
    logic [7:0]          o_s_arlen, o_s_awlen;
    logic [2:0]          o_s_arsize, o_s_awsize;
    logic [1:0]          o_s_arburst, o_s_awburst, s_bresp, s_rresp;
    logic                o_s_arvalid, o_s_awvalid, s_arready, s_awready;
    logic [DW-1:0]       o_s_wdata, s_rdata;
    logic [SW-1:0]       o_s_wstrb;
    logic                o_s_wlast, o_s_wvalid, s_wready;
    logic                s_bvalid, o_s_bready, s_rlast, s_rvalid, o_s_rready;

    int checks = 0;
    int fails  = 0;

    logic [IDW+32:0] ar_exp_q[$];
    logic [DW:0]     w_exp_q[$];
    logic [IDW:0]    b_exp_q[$];
    logic            win_exp_q[$];

    axi_mem_arbiter #(.ID_WIDTH(IDW), .AXI_DATA_WIDTH(DW), .MAX_W_OUTST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_m_arid(m_arid), .i_m_araddr(m_araddr), .i_m_arlen(m_arlen), .i_m_arsize(m_arsize),
        .i_m_arburst(m_arburst), .i_m_arvalid(m_arvalid), .o_m_arready(o_m_arready),
        .i_m_awid(m_awid), .i_m_awaddr(m_awaddr), .i_m_awlen(m_awlen), .i_m_awsize(m_awsize),
        .i_m_awburst(m_awburst), .i_m_awvalid(m_awvalid), .o_m_awready(o_m_awready),
        .i_m_wdata(m_wdata), .i_m_wstrb(m_wstrb), .i_m_wlast(m_wlast), .i_m_wvalid(m_wvalid),
        .o_m_wready(o_m_wready),
        .o_m_bid(o_m_bid), .o_m_bresp(o_m_bresp), .o_m_bvalid(o_m_bvalid), .i_m_bready(m_bready),
        .o_m_rid(o_m_rid), .o_m_rdata(o_m_rdata), .o_m_rresp(o_m_rresp), .o_m_rlast(o_m_rlast),
        .o_m_rvalid(o_m_rvalid), .i_m_rready(m_rready),
        .o_s_arid(o_s_arid), .o_s_araddr(o_s_araddr), .o_s_arlen(o_s_arlen), .o_s_arsize(o_s_arsize),
        .o_s_arburst(o_s_arburst), .o_s_arvalid(o_s_arvalid), .i_s_arready(s_arready),
        .o_s_awid(o_s_awid), .o_s_awaddr(o_s_awaddr), .o_s_awlen(o_s_awlen), .o_s_awsize(o_s_awsize),
        .o_s_awburst(o_s_awburst), .o_s_awvalid(o_s_awvalid), .i_s_awready(s_awready),
        .o_s_wdata(o_s_wdata), .o_s_wstrb(o_s_wstrb), .o_s_wlast(o_s_wlast), .o_s_wvalid(o_s_wvalid),
        .i_s_wready(s_wready),
        .i_s_bid(s_bid), .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid), .o_s_bready(o_s_bready),
        .i_s_rid(s_rid), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rlast(s_rlast),
        .i_s_rvalid(s_rvalid), .o_s_rready(o_s_rready)
    );

    function automatic logic [14:0] hs_outs();
        return {o_m_arready, o_m_awready, o_m_wready, o_m_bvalid, o_m_rvalid,
                o_s_arvalid, o_s_awvalid, o_s_wvalid, o_s_bready, o_s_rready};
    endfunction

    task automatic set_idle();
        m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_arvalid = '0;
        m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0; m_awvalid = '0;
        m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0;
        m_bready = 2'b11; m_rready = 2'b11;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;
        s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ar_exp_q.delete(); w_exp_q.delete(); b_exp_q.delete(); win_exp_q.delete();
    endtask

    task automatic aw_req(input bit m, input logic [IDW-1:0] id, input logic [7:0] len);
        int t;
        @(negedge clk);
        m_awvalid[m] = 1'b1; m_awid[m] = id; m_awlen[m] = len; m_awaddr[m] = {24'h0, id, 4'h0};
        #1;
        t = 0;
        while (!o_m_awready[m] && t < 20) begin
            @(negedge clk); #1; t++;
        end
        checks++;
        if ({o_m_awready[m], o_s_awid} !== {1'b1, m, id}) begin
            fails++;
            $display("[TB] FAIL aw_accept m%0d: ready/id %b/%h, required 1/%h", m, o_m_awready[m], o_s_awid, {m, id});
        end
        b_exp_q.push_back({m, id});
        @(negedge clk);
        m_awvalid[m] = 1'b0;
    endtask

    task automatic w_burst(input bit m, input int len, input logic [DW-1:0] base);
        int t;
        logic [DW:0] exp;
        for (int b = 0; b <= len; b++) begin
            m_wdata[m] = base + DW'(b); m_wstrb[m] = '1; m_wlast[m] = (b == len); m_wvalid[m] = 1'b1;
            w_exp_q.push_back({m_wlast[m], m_wdata[m]});
            #1;
            t = 0;
            while (!o_m_wready[m] && t < 20) begin
                @(negedge clk); #1; t++;
            end
            exp = w_exp_q.pop_front();
            checks++;
            if ({o_m_wready[m], o_s_wvalid, o_s_wlast, o_s_wdata} !== {2'b11, exp}) begin
                fails++;
                $display("[TB] FAIL w_beat m%0d b%0d: rdy/vld/last/data %b%b/%b/%h, required 11/%h", m, b, o_m_wready[m], o_s_wvalid, o_s_wlast, o_s_wdata, exp);
            end
            @(negedge clk);
        end
        m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0;
    endtask

    task automatic aw_burst(input bit m, input logic [IDW-1:0] id, input int len);
        aw_req(m, id, 8'(len));
        w_burst(m, len, {56'h0, id, 4'h0});
    endtask

    task automatic drain_b(input int n);
        logic [IDW:0] exp;
        logic         dst;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            exp = b_exp_q.pop_front();
            dst = exp[IDW];
            s_bid = exp; s_bresp = 2'(k); s_bvalid = 1'b1;
            #1;
            checks++;
            if ({o_m_bvalid, o_m_bid[dst], o_m_bresp[dst], o_s_bready} !== {(dst ? 2'b10 : 2'b01), exp[IDW-1:0], 2'(k), 1'b1}) begin
                fails++;
                $display("[TB] FAIL b_route sid %h: bvalid %b bid %h bresp %0d bready %b", exp, o_m_bvalid, o_m_bid[dst], o_m_bresp[dst], o_s_bready);
            end
        end
        @(negedge clk);
        s_bvalid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_arvalid = 2'b11; m_awvalid = 2'b11; m_wvalid = 2'b11; m_wlast = 2'b11;
        s_rvalid = 1'b1; s_bvalid = 1'b1; s_bid = 5'h10; s_rid = 5'h10;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++;
            if (hs_outs() !== 15'h0) begin
                fails++;
                $display("[TB] FAIL reset_outs cycle %0d: %b, required all 0", c, hs_outs());
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        s_arready = 1'b0;
        m_arvalid = 2'b11; m_arid[0] = M0_ID; m_arid[1] = M1_ID;
        #1;
        checks++;
        if ({o_s_arvalid, o_s_arid} !== {1'b1, 1'b0, M0_ID}) begin
            fails++;
            $display("[TB] FAIL reset_first_grant: vld/id %b/%h, required 1/%h", o_s_arvalid, o_s_arid, {1'b0, M0_ID});
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_ar_round_robin();
        logic [IDW+32:0] exp;
        logic [IDW:0]    r_sid [4];
        logic [1:0]      r_rdy [4];
        logic            dst;
        for (int i = 0; i < 4; i++)
            ar_exp_q.push_back((i % 2 == 0) ? {1'b0, M0_ID, 32'h0000_1000} : {1'b1, M1_ID, 32'h0000_2000});
        @(negedge clk);
        m_arvalid = 2'b11; m_arid[0] = M0_ID; m_arid[1] = M1_ID;
        m_araddr[0] = 32'h0000_1000; m_araddr[1] = 32'h0000_2000;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp = ar_exp_q.pop_front();
            checks++;
            if ({o_s_arvalid, o_s_arid, o_s_araddr, o_m_arready} !== {1'b1, exp, (exp[IDW+32] ? 2'b10 : 2'b01)}) begin
                fails++;
                $display("[TB] FAIL ar_rr grant %0d: id %h addr %h ready %b, required %h", i, o_s_arid, o_s_araddr, o_m_arready, exp);
            end
            @(negedge clk);
        end
        m_arvalid = 2'b10; s_arready = 1'b0;
        #1;
        @(negedge clk);
        m_arvalid = 2'b11;
        #1;
        checks++;
        if ({o_s_arvalid, o_s_arid} !== {1'b1, 1'b1, M1_ID}) begin
            fails++;
            $display("[TB] FAIL ar_hold: vld/id %b/%h, required 1/%h", o_s_arvalid, o_s_arid, {1'b1, M1_ID});
        end
        s_arready = 1'b1;
        #1;
        checks++;
        if (o_m_arready !== 2'b10) begin
            fails++;
            $display("[TB] FAIL ar_hold_ready: %b, required 10", o_m_arready);
        end
        @(negedge clk);
        m_arvalid = 2'b00;
        r_sid = '{5'h03, 5'h1A, 5'h15, 5'h0C};
        r_rdy = '{2'b01, 2'b00, 2'b10, 2'b11};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dst = r_sid[i][IDW];
            s_rid = r_sid[i]; s_rdata = 64'hBEEF_0000 + 64'(i); s_rresp = 2'(i); s_rlast = 1'b1; s_rvalid = 1'b1;
            m_rready = r_rdy[i];
            #1;
            checks++;
            if ({o_m_rvalid, o_m_rid[dst], o_m_rdata[dst], o_m_rresp[dst], o_s_rready} !==
                {(dst ? 2'b10 : 2'b01), r_sid[i][IDW-1:0], 64'hBEEF_0000 + 64'(i), 2'(i), r_rdy[i][dst]}) begin
                fails++;
                $display("[TB] FAIL r_route sid %h: rvalid %b rid %h rdata %h rready %b", r_sid[i], o_m_rvalid, o_m_rid[dst], o_m_rdata[dst], o_s_rready);
            end
        end
        @(negedge clk);
        s_rvalid = 1'b0; m_rready = 2'b11;
    endtask

    task automatic test_w_lock();
        logic [DW:0] exp;
        @(negedge clk);
        m_awvalid = 2'b10; m_awid[1] = M1_ID; m_awlen[1] = 8'd3;
        #1;
        checks++;
        if ({o_m_awready, o_s_awid, o_s_awlen} !== {2'b10, 1'b1, M1_ID, 8'd3}) begin
            fails++;
            $display("[TB] FAIL w_lock_aw1: ready %b id %h len %0d, required 10/%h/3", o_m_awready, o_s_awid, o_s_awlen, {1'b1, M1_ID});
        end
        b_exp_q.push_back({1'b1, M1_ID});
        @(negedge clk);
        m_awvalid = 2'b01; m_awid[0] = M0_ID; m_awlen[0] = 8'd0;
        for (int b = 0; b < 4; b++) begin
            m_wdata[1] = 64'h1000 + 64'(b); m_wstrb[1] = '1; m_wlast[1] = (b == 3); m_wvalid[1] = 1'b1;
            w_exp_q.push_back({m_wlast[1], m_wdata[1]});
            #1;
            checks++;
            if ({o_m_awready, o_s_awvalid, o_m_wready} !== 5'b00010) begin
                fails++;
                $display("[TB] FAIL w_lock_stall beat %0d: awready %b awvalid %b wready %b, required 00/0/10", b, o_m_awready, o_s_awvalid, o_m_wready);
            end
            exp = w_exp_q.pop_front();
            checks++;
            if ({o_s_wvalid, o_s_wlast, o_s_wdata} !== {1'b1, exp}) begin
                fails++;
                $display("[TB] FAIL w_lock_data beat %0d: %b/%h, required 1/%h", b, o_s_wvalid, {o_s_wlast, o_s_wdata}, exp);
            end
            @(negedge clk);
        end
        m_wvalid = 2'b00; m_wlast = 2'b00;
        #1;
        checks++;
        if ({o_m_awready, o_s_awid} !== {2'b01, 1'b0, M0_ID}) begin
            fails++;
            $display("[TB] FAIL w_lock_aw0: ready %b id %h, required 01/%h", o_m_awready, o_s_awid, {1'b0, M0_ID});
        end
        b_exp_q.push_back({1'b0, M0_ID});
        @(negedge clk);
        m_awvalid = 2'b00;
        w_burst(1'b0, 0, 64'hD00D);
        drain_b(2);
    endtask

    task automatic test_outstanding();
        logic [IDW:0] exp;
        for (int i = 0; i < 4; i++)
            aw_burst(1'b0, IDW'(i + 1), 0);
        @(negedge clk);
        m_awvalid[0] = 1'b1; m_awid[0] = 4'h5; m_awlen[0] = 8'd0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({o_m_awready, o_s_awvalid} !== 3'b000) begin
                fails++;
                $display("[TB] FAIL outst_stall %0d: awready %b awvalid %b, required 00/0", c, o_m_awready, o_s_awvalid);
            end
            @(negedge clk);
        end
        exp = b_exp_q.pop_front();
        s_bid = exp; s_bresp = 2'b00; s_bvalid = 1'b1;
        #1;
        checks++;
        if ({o_m_awready, o_m_bvalid, o_s_bready} !== 5'b00011) begin
            fails++;
            $display("[TB] FAIL outst_b_cycle: awready %b bvalid %b bready %b, required 00/01/1", o_m_awready, o_m_bvalid, o_s_bready);
        end
        @(negedge clk);
        s_bvalid = 1'b0;
        #1;
        checks++;
        if ({o_m_awready, o_s_awid} !== {2'b01, 1'b0, 4'h5}) begin
            fails++;
            $display("[TB] FAIL outst_release: ready %b id %h, required 01/05", o_m_awready, o_s_awid);
        end
        b_exp_q.push_back({1'b0, 4'h5});
        @(negedge clk);
        m_awvalid = 2'b00;
        w_burst(1'b0, 0, 64'h50);
        drain_b(1);
        @(negedge clk);
        m_awvalid[0] = 1'b1; m_awid[0] = 4'h6; m_awlen[0] = 8'd0;
        exp = b_exp_q.pop_front();
        s_bid = exp; s_bvalid = 1'b1;
        #1;
        checks++;
        if ({o_m_awready, o_s_bready} !== 3'b011) begin
            fails++;
            $display("[TB] FAIL outst_simul: awready %b bready %b, required 01/1", o_m_awready, o_s_bready);
        end
        b_exp_q.push_back({1'b0, 4'h6});
        @(negedge clk);
        m_awvalid = 2'b00; s_bvalid = 1'b0;
        w_burst(1'b0, 0, 64'h60);
        aw_burst(1'b0, 4'h7, 0);
        @(negedge clk);
        m_awvalid[0] = 1'b1; m_awid[0] = 4'h8;
        #1;
        checks++;
        if ({o_m_awready, o_s_awvalid} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL outst_full_again: awready %b awvalid %b, required 00/0", o_m_awready, o_s_awvalid);
        end
        @(negedge clk);
        m_awvalid = 2'b00;
        drain_b(b_exp_q.size());
    endtask

    task automatic test_reset_midburst();
        logic [DW:0] exp;
        aw_req(1'b0, 4'h2, 8'd3);
        for (int b = 0; b < 2; b++) begin
            m_wdata[0] = 64'h7700 + 64'(b); m_wstrb[0] = '1; m_wlast[0] = 1'b0; m_wvalid[0] = 1'b1;
            w_exp_q.push_back({1'b0, m_wdata[0]});
            #1;
            exp = w_exp_q.pop_front();
            checks++;
            if ({o_m_wready[0], o_s_wvalid, o_s_wlast, o_s_wdata} !== {2'b11, exp}) begin
                fails++;
                $display("[TB] FAIL midburst_beat %0d: %b%b/%h, required 11/%h", b, o_m_wready[0], o_s_wvalid, {o_s_wlast, o_s_wdata}, exp);
            end
            @(negedge clk);
        end
        m_wdata[0] = 64'h7702;
        rst_n = 1'b0;
        #1;
        checks++;
        if (hs_outs() !== 15'h0) begin
            fails++;
            $display("[TB] FAIL midburst_reset_outs: %b, required all 0", hs_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        w_exp_q.delete(); b_exp_q.delete();
        #1;
        checks++;
        if ({o_m_wready, o_s_wvalid} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL midburst_idle: wready %b wvalid %b, required 00/0", o_m_wready, o_s_wvalid);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_arb_fairness();
        logic exp;
        int   wins0 = 0;
        int   wins1 = 0;
        int   exp0;
        do_reset();
        @(negedge clk);
        m_arvalid = 2'b11; m_arid[0] = M0_ID; m_arid[1] = M1_ID;
        for (int i = 0; i < 10; i++) begin
`ifdef AXI_MEM_ARB_FIXED_PRIO_EN
            win_exp_q.push_back(1'b0);
`else
            win_exp_q.push_back(i[0]);
`endif
            #1;
            exp = win_exp_q.pop_front();
            checks++;
            if (o_m_arready !== (exp ? 2'b10 : 2'b01)) begin
                fails++;
                $display("[TB] FAIL arb_cycle %0d: arready %b, required winner M%0d", i, o_m_arready, exp);
            end
            if (o_m_arready[0]) wins0++;
            if (o_m_arready[1]) wins1++;
            @(negedge clk);
        end
        m_arvalid = 2'b00;
`ifdef AXI_MEM_ARB_FIXED_PRIO_EN
        exp0 = 10;
`else
        exp0 = 5;
`endif
        checks++;
        if (wins0 != exp0 || wins1 != 10 - exp0) begin
            fails++;
            $display("[TB] FAIL arb_totals: M0 %0d M1 %0d, required %0d/%0d", wins0, wins1, exp0, 10 - exp0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        set_idle();
        test_reset();
        test_ar_round_robin();
        test_w_lock();
        test_outstanding();
        test_reset_midburst();
        test_arb_fairness();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
